cm_coef_loader: RTL and testbench

- Producer side of the complex-multiply coefficient interface: assembles the six 16-bit coefficient words consumed as int1_real..int3_img from a framed word stream on din.
- Holds a validated frame as pending. Commits it to the active outputs only on a scen_ch pulse, so the multiplier never sees a partially loaded coefficient set.
- Sits between the tiny_tapeout input pins and the cm datapath, in the CLK domain.

---
 rtl/cm_coef_loader.sv | 156 +++++++++++++++
 tb/tb_cm_coef_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cm_coef_loader.sv
// Assembles a framed six-word complex-multiply coefficient set from din and commits it on scen_ch.
// Define LOADER_CKSUM_EN to append and check an XOR checksum word; otherwise frames are SYNC + 6 words.
module cm_coef_loader #(
    parameter int              DW        = 16,
    parameter logic [DW-1:0]   SYNC_WORD = 16'hA5C3,
    parameter int              ERR_W     = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             din_valid,
    input  logic [DW-1:0]    din,
    input  logic             scen_ch,
    output logic             busy,
    output logic             pending,
    output logic             apply,
    output logic [ERR_W-1:0] err_cnt,
    output logic [DW-1:0]    int1_real,
    output logic [DW-1:0]    int1_img,
    output logic [DW-1:0]    int2_real,
    output logic [DW-1:0]    int2_img,
    output logic [DW-1:0]    int3_real,
    output logic [DW-1:0]    int3_img
);

    localparam int NW = 6;

    typedef enum logic [1:0] {S_HUNT, S_LOAD, S_CHECK} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_idx;
    logic [DW-1:0] r_stage [NW];
    logic [DW-1:0] r_pend  [NW];
    logic [DW-1:0] r_act   [NW];
    logic          r_pending;
    logic          r_apply;

    logic w_sync;
    logic w_take;
    logic w_last;
    logic w_good;
    logic w_commit;

    assign w_sync   = (r_state == S_HUNT) && din_valid && (din == SYNC_WORD);
    assign w_take   = (r_state == S_LOAD) && din_valid;
    assign w_last   = w_take && (r_idx == 3'd5);
    // Commit uses the old pending flag, so a set validated this same edge waits for the next strobe.
    assign w_commit = scen_ch && r_pending;

`ifdef LOADER_CKSUM_EN
    logic [DW-1:0]    r_cksum;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_bad;

    assign w_good = (r_state == S_CHECK) && din_valid && (din == r_cksum);
    assign w_bad  = (r_state == S_CHECK) && din_valid && (din != r_cksum);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cksum   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_sync)
                r_cksum <= '0;
            else if (w_take)
                r_cksum <= r_cksum ^ din;
            if (w_bad && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign w_good  = w_last;
    assign err_cnt = '0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (reset)
            r_state <= S_HUNT;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HUNT:  if (w_sync) w_state_next = S_LOAD;
`ifdef LOADER_CKSUM_EN
            S_LOAD:  if (w_last) w_state_next = S_CHECK;
            S_CHECK: if (din_valid) w_state_next = S_HUNT;
`else
            S_LOAD:  if (w_last) w_state_next = S_HUNT;
`endif
            default: w_state_next = S_HUNT;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state != S_HUNT);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_apply   <= 1'b0;
        end else begin
            if (w_sync)
                r_idx <= '0;
            else if (w_take)
                r_idx <= r_idx + 3'd1;
            if (w_good)
                r_pending <= 1'b1;
            else if (w_commit)
                r_pending <= 1'b0;
            r_apply <= w_commit;
        end
    end

    // Per-lane staging, pending and active registers; the last data word bypasses staging.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_lane
            logic w_wr;
            assign w_wr = w_take && (r_idx == 3'(gi));

            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_stage[gi] <= '0;
                    r_pend[gi]  <= '0;
                    r_act[gi]   <= '0;
                end else begin
                    if (w_wr)
                        r_stage[gi] <= din;
                    if (w_good)
                        r_pend[gi] <= w_wr ? din : r_stage[gi];
                    if (w_commit)
                        r_act[gi] <= r_pend[gi];
                end
            end
        end
    endgenerate

    assign pending   = r_pending;
    assign apply     = r_apply;
    assign int1_real = r_act[0];
    assign int1_img  = r_act[1];
    assign int2_real = r_act[2];
    assign int2_img  = r_act[3];
    assign int3_real = r_act[4];
    assign int3_img  = r_act[5];

endmodule

// File: tb/tb_cm_coef_loader.sv
// Directed bench for cm_coef_loader: frame table plus commit, overlap, reset and saturation sequences.
module tb_cm_coef_loader;

`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic        din_valid;
    logic [15:0] din;
    logic        scen_ch;
    logic        busy, pending, apply;
    logic [7:0]  err_cnt;
    logic [15:0] int1_real, int1_img, int2_real, int2_img, int3_real, int3_img;

    cm_coef_loader dut (
        .CLK(CLK), .reset(reset), .din_valid(din_valid), .din(din), .scen_ch(scen_ch),
        .busy(busy), .pending(pending), .apply(apply), .err_cnt(err_cnt),
        .int1_real(int1_real), .int1_img(int1_img), .int2_real(int2_real),
        .int2_img(int2_img), .int3_real(int3_real), .int3_img(int3_img)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0][15:0] w;
        logic [15:0]      ck;
        logic             good;
        logic             stall;
        logic             garbage;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0][15:0] exp_act;
    logic [7:0]       exp_err;
    logic             exp_pend;
    vec_t             vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_act(input string tag, input logic [5:0][15:0] e);
        chk({tag, ".int1_real"}, {16'h0, int1_real}, {16'h0, e[0]});
        chk({tag, ".int1_img"},  {16'h0, int1_img},  {16'h0, e[1]});
        chk({tag, ".int2_real"}, {16'h0, int2_real}, {16'h0, e[2]});
        chk({tag, ".int2_img"},  {16'h0, int2_img},  {16'h0, e[3]});
        chk({tag, ".int3_real"}, {16'h0, int3_real}, {16'h0, e[4]});
        chk({tag, ".int3_img"},  {16'h0, int3_img},  {16'h0, e[5]});
    endtask

    // One valid word; a stall cycle presents the sync word with din_valid low to prove it is ignored.
    task automatic word(input logic [15:0] d, input logic stall, input logic sc);
        din_valid = 1'b1;
        din       = d;
        scen_ch   = sc;
        @(negedge CLK);
        din_valid = 1'b0;
        scen_ch   = 1'b0;
        din       = 16'hA5C3;
        if (stall) @(negedge CLK);
    endtask

    task automatic send_frame(input vec_t v, input logic scen_last, input logic chk_w5);
        if (v.garbage) begin
            word(16'h1234, v.stall, 1'b0);
            word(16'hFFFF, v.stall, 1'b0);
        end
        word(16'hA5C3, v.stall, 1'b0);
        chk("busy_after_sync", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 5; i++) word(v.w[i], v.stall, 1'b0);
        word(v.w[5], v.stall, scen_last && !CK);
        if (chk_w5) begin
            chk("pending_after_w5", {31'h0, pending}, {31'h0, !CK});
            chk("busy_after_w5",    {31'h0, busy},    {31'h0, CK});
        end
        if (scen_last && !CK) chk("apply_on_overlap", {31'h0, apply}, 32'h1);
        word(v.ck, v.stall, scen_last && CK);
        if (scen_last && CK) chk("apply_on_overlap", {31'h0, apply}, 32'h1);
    endtask

    task automatic pulse_scen();
        scen_ch = 1'b1;
        @(negedge CLK);
        scen_ch = 1'b0;
    endtask

    initial begin
        vecs[0] = '{w: {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001},
                    ck: 16'h0007, good: 1'b1, stall: 1'b0, garbage: 1'b0};
        vecs[1] = '{w: {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001},
                    ck: 16'h0007, good: 1'b1, stall: 1'b1, garbage: 1'b1};
        vecs[2] = '{w: {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001},
                    ck: 16'h0000, good: 1'b0, stall: 1'b0, garbage: 1'b0};
        vecs[3] = '{w: {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                    ck: 16'h7777, good: 1'b1, stall: 1'b0, garbage: 1'b0};
        vecs[4] = '{w: {16'h0060, 16'h0050, 16'h0040, 16'hA5C3, 16'h0020, 16'h0010},
                    ck: 16'hA583, good: 1'b1, stall: 1'b1, garbage: 1'b0};

        reset = 1'b1; din_valid = 1'b0; din = 16'h0; scen_ch = 1'b0;
        exp_act = '0;
        exp_err = '0;
        repeat (2) @(negedge CLK);
        chk("reset.busy",    {31'h0, busy},    32'h0);
        chk("reset.pending", {31'h0, pending}, 32'h0);
        chk("reset.apply",   {31'h0, apply},   32'h0);
        chk("reset.err_cnt", {24'h0, err_cnt}, 32'h0);
        chk_act("reset", exp_act);
        reset = 1'b0;
        @(negedge CLK);

        // Table: load a frame, check it is pending but inactive, then commit it.
        for (int k = 0; k < 5; k++) begin
            send_frame(vecs[k], 1'b0, 1'b1);
            exp_pend = vecs[k].good || !CK;
            if (CK && !vecs[k].good) exp_err = exp_err + 8'd1;
            chk("vec.pending", {31'h0, pending}, {31'h0, exp_pend});
            chk("vec.err_cnt", {24'h0, err_cnt}, {24'h0, exp_err});
            chk_act("vec.before_commit", exp_act);
            pulse_scen();
            chk("vec.apply", {31'h0, apply}, {31'h0, exp_pend});
            if (exp_pend) exp_act = vecs[k].w;
            chk_act("vec.after_commit", exp_act);
            chk("vec.pending_cleared", {31'h0, pending}, 32'h0);
            @(negedge CLK);
            chk("vec.apply_one_cycle", {31'h0, apply}, 32'h0);
            $display("[TB] vec %0d: pending=%0b err_cnt=%0d int1_real=%h int3_img=%h",
                     k, exp_pend, err_cnt, int1_real, int3_img);
        end

        // Commit strobe coinciding with a good frame: older set commits, newer becomes pending.
        send_frame(vecs[0], 1'b0, 1'b0);
        send_frame(vecs[3], 1'b1, 1'b0);
        exp_act = vecs[0].w;
        chk_act("overlap.old_active", exp_act);
        chk("overlap.pending", {31'h0, pending}, 32'h1);
        chk("overlap.apply_dropped", {31'h0, apply}, 32'h0);
        pulse_scen();
        exp_act = vecs[3].w;
        chk_act("overlap.new_active", exp_act);
        chk("overlap.apply2", {31'h0, apply}, 32'h1);
        $display("[TB] overlap: int1_real=%h pending=%0b", int1_real, pending);

        // scen_ch held for three cycles commits exactly once.
        send_frame(vecs[4], 1'b0, 1'b0);
        scen_ch = 1'b1;
        @(negedge CLK);
        exp_act = vecs[4].w;
        chk("hold.apply_first", {31'h0, apply}, 32'h1);
        @(negedge CLK);
        chk("hold.apply_second", {31'h0, apply}, 32'h0);
        @(negedge CLK);
        chk("hold.apply_third", {31'h0, apply}, 32'h0);
        scen_ch = 1'b0;
        chk_act("hold", exp_act);
        $display("[TB] hold: int2_real=%h", int2_real);

        // Reset after three data words discards the partial frame.
        word(16'hA5C3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) word(16'h0F00 + 16'(i), 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        exp_act = '0;
        chk("midreset.busy",    {31'h0, busy},    32'h0);
        chk("midreset.pending", {31'h0, pending}, 32'h0);
        chk("midreset.err_cnt", {24'h0, err_cnt}, 32'h0);
        chk_act("midreset", exp_act);
        send_frame(vecs[0], 1'b0, 1'b0);
        chk("midreset.reload_pending", {31'h0, pending}, 32'h1);
        pulse_scen();
        exp_act = vecs[0].w;
        chk_act("midreset.reload", exp_act);
        $display("[TB] midreset: int3_img=%h", int3_img);

        // 256 rejected frames saturate the error counter.
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        for (int n = 0; n < 256; n++) send_frame(vecs[2], 1'b0, 1'b0);
        chk("saturate.err_cnt", {24'h0, err_cnt}, CK ? 32'hFF : 32'h0);
        chk("saturate.pending", {31'h0, pending}, {31'h0, !CK});
        $display("[TB] saturate: err_cnt=%h", err_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
